// File: rtl/usb_ep_fifo.sv
// usb_ep_fifo: byte FIFO for one USB endpoint. OUT bytes are appended; IN packets of
// up to MAX_PKT bytes are read first-word-fall-through and replayed if the IN aborts.
//   state | meaning
//   IDLE  | no packet open; txcork reports an empty FIFO
//   SEND  | packet latched, txval high while bytes remain
//   DONE  | packet fully popped, waiting for txact to drop
module usb_ep_fifo #(
  parameter int DEPTH   = 64,
  parameter int EP_NUM  = 1,
  parameter int MAX_PKT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             endpt,
  input  logic                   rxact,
  input  logic                   rxval,
  input  logic [7:0]             rxdat,
  output logic                   rxrdy,
  input  logic                   txact,
  input  logic                   txpop,
  output logic                   txval,
  output logic                   txcork,
  output logic [7:0]             txdat,
  output logic [11:0]            txdat_len,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (CW > 12) ? CW : 12;

  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_e;

  tx_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_save_q, rd_save_d;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [LW-1:0] len_q, len_d;
  logic          txcork_q, txcork_d;
  logic [7:0]    mem [DEPTH];

  logic          sel, tx_on, wr_en, pop, full;
  logic [LW-1:0] count_ext, pkt_len;

  assign sel       = (endpt == 4'(EP_NUM));
  assign full      = (count_q == CW'(DEPTH));
  assign rxrdy     = !rst && !full;
  assign wr_en     = rxact && rxval && rxrdy && sel;
  assign tx_on     = txact && sel;
  assign txval     = (state_q == SEND) && (remain_q != '0);
  assign pop       = tx_on && txpop && txval;
  assign count_ext = LW'(count_q);
  assign pkt_len   = (count_ext > LW'(MAX_PKT)) ? LW'(MAX_PKT) : count_ext;
  assign txdat     = mem[rd_ptr_q];
  assign txdat_len = len_q[11:0];
  assign count     = count_q;
  assign txcork    = txcork_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= rxdat;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_save_d = rd_save_q;
    count_d   = count_q;
    remain_d  = remain_q;
    len_d     = len_q;
    unique case (state_q)
      IDLE: begin
        if (tx_on && (count_q != '0)) begin
          len_d     = pkt_len;
          remain_d  = pkt_len;
          rd_save_d = rd_ptr_q;
          state_d   = SEND;
        end
      end
      SEND: begin
        // Dropping txact mid-packet hands the popped bytes back for a full replay.
        if (!tx_on) begin
          rd_ptr_d = rd_save_q;
          count_d  = count_q + CW'(len_q - remain_q);
          remain_d = '0;
          len_d    = '0;
          state_d  = IDLE;
        end else if (pop) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
          remain_d = remain_q - LW'(1);
          if (remain_q == LW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!tx_on) begin
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_d + CW'(1);
    end
    txcork_d = (state_d == IDLE) && (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_save_q <= '0;
      count_q   <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      txcork_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_save_q <= rd_save_d;
      count_q   <= count_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      txcork_q  <= txcork_d;
    end
  end

endmodule

// File: tb/tb_usb_ep_fifo.sv
// tb_usb_ep_fifo: two instances (64-deep/16-byte packets and 4-deep/4-byte packets)
// checked every cycle against a byte-stream model, plus directed literal checks.
module tb_usb_ep_fifo;
  localparam int DA = 64, MA = 16, DB = 4, MB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] endpt_a, endpt_b;
  logic       rxact, rxval, txact, txpop;
  logic [7:0] rxdat;

  logic       rxrdy_a, txval_a, txcork_a;
  logic [7:0] txdat_a;
  logic [11:0] txdat_len_a;
  logic [6:0] count_a;
  logic       rxrdy_b, txval_b, txcork_b;
  logic [7:0] txdat_b;
  logic [11:0] txdat_len_b;
  logic [2:0] count_b;

  always #5 clk = ~clk;

  usb_ep_fifo #(.DEPTH(DA), .EP_NUM(1), .MAX_PKT(MA)) u_a (
    .clk(clk), .rst(rst), .endpt(endpt_a), .rxact(rxact), .rxval(rxval), .rxdat(rxdat),
    .rxrdy(rxrdy_a), .txact(txact), .txpop(txpop), .txval(txval_a), .txcork(txcork_a),
    .txdat(txdat_a), .txdat_len(txdat_len_a), .count(count_a));

  usb_ep_fifo #(.DEPTH(DB), .EP_NUM(1), .MAX_PKT(MB)) u_b (
    .clk(clk), .rst(rst), .endpt(endpt_b), .rxact(rxact), .rxval(rxval), .rxdat(rxdat),
    .rxrdy(rxrdy_b), .txact(txact), .txpop(txpop), .txval(txval_b), .txcork(txcork_b),
    .txdat(txdat_b), .txdat_len(txdat_len_b), .count(count_b));

  int nvec = 0, nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    nvec++;
    if (act !== 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: every accepted byte is appended to a log; ncons bytes are gone for good,
  // nsent bytes of the open packet are popped but still replayable.
  logic [7:0] mlog [2][1024];
  int nwr[2]   = '{0, 0};
  int ncons[2] = '{0, 0};
  int nsent[2] = '{0, 0};
  int plen[2]  = '{0, 0};
  int mst[2]   = '{0, 0};
  int mdepth[2] = '{DA, DB};
  int mmax[2]   = '{MA, MB};

  function automatic int mcount(input int i);
    return nwr[i] - ncons[i] - nsent[i];
  endfunction

  always @(posedge clk) begin
    logic [3:0] ep;
    bit s, t, w;
    int c;
    for (int i = 0; i < 2; i++) begin
      ep = (i == 0) ? endpt_a : endpt_b;
      c  = mcount(i);
      if (rst) begin
        nwr[i] = 0; ncons[i] = 0; nsent[i] = 0; plen[i] = 0; mst[i] = 0;
      end else begin
        s = (ep == 4'd1);
        t = txact && s;
        w = rxact && rxval && s && (c < mdepth[i]);
        case (mst[i])
          0: if (t && c > 0) begin
               plen[i] = (c < mmax[i]) ? c : mmax[i];
               nsent[i] = 0;
               mst[i] = 1;
             end
          1: if (!t) begin
               nsent[i] = 0; plen[i] = 0; mst[i] = 0;
             end else if (txpop) begin
               nsent[i]++;
               if (nsent[i] == plen[i]) begin
                 ncons[i] += plen[i]; nsent[i] = 0; mst[i] = 2;
               end
             end
          2: if (!t) begin
               plen[i] = 0; mst[i] = 0;
             end
          default: ;
        endcase
        if (w) begin
          mlog[i][nwr[i] % 1024] = rxdat;
          nwr[i]++;
        end
      end
    end
  end

  always @(posedge clk) begin
    string p;
    int c, idx;
    #2;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "a" : "b";
      c = mcount(i);
      chk({p, ".rxrdy"},  (i == 0) ? 32'(rxrdy_a)  : 32'(rxrdy_b),  int'(!rst && c != mdepth[i]));
      chk({p, ".txcork"}, (i == 0) ? 32'(txcork_a) : 32'(txcork_b), int'(mst[i] == 0 && c == 0));
      chk({p, ".txval"},  (i == 0) ? 32'(txval_a)  : 32'(txval_b),  int'(mst[i] == 1));
      chk({p, ".txdat_len"}, (i == 0) ? 32'(txdat_len_a) : 32'(txdat_len_b), plen[i]);
      chk({p, ".count"},  (i == 0) ? 32'(count_a)  : 32'(count_b),  c);
      idx = ncons[i] + nsent[i];
      if (idx < nwr[i])
        chk({p, ".txdat"}, (i == 0) ? 32'(txdat_a) : 32'(txdat_b), int'(mlog[i][idx % 1024]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rxact = 1'b0; rxval = 1'b0; rxdat = 8'h00; txact = 1'b0; txpop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs(); tick(); tick(); rst = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rxact = 1'b1; rxval = 1'b1; rxdat = b; tick();
    rxact = 1'b0; rxval = 1'b0;
  endtask

  initial begin
    logic [7:0] nxt, exp;
    endpt_a = 4'd1; endpt_b = 4'd0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); tick();
    chk("rst.txcork", 32'(txcork_a), 1);
    chk("rst.rxrdy", 32'(rxrdy_a), 0);
    chk("rst.count", 32'(count_a), 0);
    chk("rst.len", 32'(txdat_len_a), 0);
    chk("rst.txval", 32'(txval_a), 0);
    rst = 1'b0; #1;
    chk("rst.rxrdy_release", 32'(rxrdy_a), 1);

    // loopback
    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
    chk("lb.count", 32'(count_a), 3);
    chk("lb.cork_busy", 32'(txcork_a), 0);
    txact = 1'b1; tick();
    chk("lb.len", 32'(txdat_len_a), 3);
    chk("lb.txval", 32'(txval_a), 1);
    txpop = 1'b1;
    chk("lb.d0", 32'(txdat_a), 8'h11); tick();
    chk("lb.d1", 32'(txdat_a), 8'h22); tick();
    chk("lb.d2", 32'(txdat_a), 8'h33); tick();
    chk("lb.done_txval", 32'(txval_a), 0);
    chk("lb.done_count", 32'(count_a), 0);
    chk("lb.len_stable", 32'(txdat_len_a), 3);
    txpop = 1'b0; txact = 1'b0; tick();
    chk("lb.idle_len", 32'(txdat_len_a), 0);
    chk("lb.idle_cork", 32'(txcork_a), 1);

    // empty IN is corked
    txact = 1'b1; tick(); tick();
    chk("empty.cork", 32'(txcork_a), 1);
    chk("empty.txval", 32'(txval_a), 0);
    chk("empty.len", 32'(txdat_len_a), 0);
    txact = 1'b0; tick();

    // traffic for another endpoint is ignored
    wr_byte(8'h44); wr_byte(8'h45);
    endpt_a = 4'd2; rxact = 1'b1; rxval = 1'b1; rxdat = 8'h99; txact = 1'b1; txpop = 1'b1;
    tick(); tick(); tick();
    chk("ep.count", 32'(count_a), 2);
    chk("ep.txval", 32'(txval_a), 0);
    chk("ep.len", 32'(txdat_len_a), 0);
    idle_inputs(); endpt_a = 4'd1; tick();

    // abort and replay
    do_reset();
    for (int k = 0; k < 4; k++) wr_byte(8'hA0 + 8'(k));
    txact = 1'b1; tick();
    chk("ab.len", 32'(txdat_len_a), 4);
    txpop = 1'b1; tick(); tick();
    chk("ab.mid_count", 32'(count_a), 2);
    chk("ab.mid_dat", 32'(txdat_a), 8'hA2);
    txact = 1'b0; txpop = 1'b0; tick();
    chk("ab.restored", 32'(count_a), 4);
    txact = 1'b1; tick();
    chk("ab.relen", 32'(txdat_len_a), 4);
    chk("ab.replay", 32'(txdat_a), 8'hA0);
    txpop = 1'b1; tick(); tick();
    txact = 1'b0; txpop = 1'b0; rxact = 1'b1; rxval = 1'b1; rxdat = 8'hA4; tick();
    rxact = 1'b0; rxval = 1'b0;
    chk("ab.restore_wr", 32'(count_a), 5);
    txact = 1'b1; tick();
    chk("ab.len5", 32'(txdat_len_a), 5);
    chk("ab.replay2", 32'(txdat_a), 8'hA0);
    txpop = 1'b1; repeat (5) tick(); txpop = 1'b0;
    chk("ab.drained", 32'(count_a), 0);
    chk("ab.done_txval", 32'(txval_a), 0);
    txact = 1'b0; tick();

    // fill past capacity, packet split at MAX_PKT
    do_reset();
    rxact = 1'b1; rxval = 1'b1;
    for (int k = 0; k < 65; k++) begin rxdat = 8'(k); tick(); end
    rxact = 1'b0; rxval = 1'b0;
    chk("full.count", 32'(count_a), 64);
    chk("full.rxrdy", 32'(rxrdy_a), 0);
    txact = 1'b1; tick();
    chk("full.len", 32'(txdat_len_a), 16);
    chk("full.head", 32'(txdat_a), 8'h00);
    txpop = 1'b1; repeat (16) tick(); txpop = 1'b0;
    chk("full.after_pkt", 32'(count_a), 48);
    chk("full.done_txval", 32'(txval_a), 0);
    txact = 1'b0; tick(); txact = 1'b1; tick();
    chk("full.len2", 32'(txdat_len_a), 16);
    chk("full.head2", 32'(txdat_a), 8'h10);

    // reset while sending
    rst = 1'b1; #1;
    chk("rsend.cork", 32'(txcork_a), 1);
    chk("rsend.count", 32'(count_a), 0);
    chk("rsend.txval", 32'(txval_a), 0);
    tick(); rst = 1'b0; tick();
    chk("rsend.in_cork", 32'(txcork_a), 1);
    chk("rsend.in_txval", 32'(txval_a), 0);
    txact = 1'b0; tick();

    // 4-deep wrap with simultaneous write and pop
    endpt_a = 4'd0; endpt_b = 4'd1;
    wr_byte(8'h80); wr_byte(8'h81);
    chk("wrap.count0", 32'(count_b), 2);
    nxt = 8'h82; exp = 8'h80;
    for (int pk = 0; pk < 5; pk++) begin
      txact = 1'b1; tick();
      chk("wrap.len", 32'(txdat_len_b), 2);
      for (int j = 0; j < 2; j++) begin
        chk("wrap.dat", 32'(txdat_b), int'(exp));
        exp = exp + 8'd1;
        txpop = 1'b1; rxact = 1'b1; rxval = 1'b1; rxdat = nxt; nxt = nxt + 8'd1;
        tick();
        chk("wrap.count", 32'(count_b), 2);
      end
      txpop = 1'b0; rxact = 1'b0; rxval = 1'b0; txact = 1'b0; tick();
    end
    chk("wrap.head", 32'(txdat_b), 8'h8A);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
